// File: rtl/rename_map_table.sv
// Single-wide register rename stage: speculative and committed arch->phys maps with one-cycle flush restore.
// Optional RENAME_STATS_EN adds saturating rename/stall counters.
module rename_map_table #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    localparam int PW = $clog2(PHYS_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_src1,
    input  logic [4:0]    in_src2,
    input  logic [4:0]    in_dst,
    input  logic          in_dst_wr,
    output logic          alloc_en,
    input  logic [PW-1:0] alloc_phys,
    input  logic          alloc_valid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_psrc1,
    output logic [PW-1:0] out_psrc2,
    output logic [PW-1:0] out_pdst,
    output logic [PW-1:0] out_old_pdst,
    output logic          out_dst_wr,
    input  logic          commit_en,
    input  logic [4:0]    commit_arch,
    input  logic [PW-1:0] commit_phys,
    input  logic          flush
`ifdef RENAME_STATS_EN
    ,
    output logic [31:0]   stat_renames,
    output logic [31:0]   stat_stalls
`endif
);

    logic [PW-1:0] spec_map      [ARCH_REGS];
    logic [PW-1:0] committed_map [ARCH_REGS];

    logic need_alloc;
    logic fire;
    logic commit_wr;

    always_comb begin
        need_alloc = in_dst_wr && (in_dst != 5'd31);
        in_ready   = (!out_valid || out_ready) && !flush;
        fire       = in_valid && in_ready && (!need_alloc || alloc_valid);
        alloc_en   = fire && need_alloc;
        commit_wr  = commit_en && (commit_arch != 5'd31);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                committed_map[i] <= PW'(i);
            end
        end else if (commit_wr) begin
            committed_map[commit_arch] <= commit_phys;
        end
    end

    // A commit landing in the flush cycle must be visible in the restored speculative map.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map[i] <= PW'(i);
            end
        end else if (flush) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                if (commit_wr && (commit_arch == 5'(i))) begin
                    spec_map[i] <= commit_phys;
                end else begin
                    spec_map[i] <= committed_map[i];
                end
            end
        end else if (alloc_en) begin
            spec_map[in_dst] <= alloc_phys;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_psrc1    <= '0;
            out_psrc2    <= '0;
            out_pdst     <= '0;
            out_old_pdst <= '0;
            out_dst_wr   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid    <= 1'b1;
            out_psrc1    <= spec_map[in_src1];
            out_psrc2    <= spec_map[in_src2];
            out_pdst     <= need_alloc ? alloc_phys : '0;
            out_old_pdst <= need_alloc ? spec_map[in_dst] : '0;
            out_dst_wr   <= need_alloc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RENAME_STATS_EN
    logic stall_cycle;
    assign stall_cycle = in_valid && need_alloc && !alloc_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_renames <= '0;
            stat_stalls  <= '0;
        end else begin
            if (alloc_en && (stat_renames != '1)) begin
                stat_renames <= stat_renames + 32'd1;
            end
            if (stall_cycle && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
